// File: rtl/lmt_writer.sv
// lmt_writer
//   Captures a free-running 64-bit timestamp whenever the security monitor
//   raises upLMT. It then writes the capture as NWORDS little-endian 16-bit
//   words into the LMT region of data memory over a ready/valid write port.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   upLMT      in   update request (level, sampled every cycle)
//   mem_ready  in   arbiter accepts the current word this cycle
//   mem_wen    out  write request valid
//   mem_addr   out  byte address of the current word (0 when idle)
//   mem_din    out  current data word (0 when idle)
//   lmt_busy   out  high from capture until the last word is accepted
//   lmt_done   out  one-cycle pulse after a complete update
//   timestamp  out  live counter value
module lmt_writer #(
   parameter logic [15:0] LMT_BASE = 16'h0040,
   parameter logic [15:0] LMT_SIZE = 16'h0020,
   parameter int unsigned NWORDS   = 4,
   parameter logic [63:0] TS_INIT  = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        upLMT,
   input  logic        mem_ready,
   output logic        mem_wen,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_din,
   output logic        lmt_busy,
   output logic        lmt_done,
   output logic [63:0] timestamp
);

   // Word count is clamped to 1..4 and to what fits in the region, so a
   // mis-sized build can never write outside the protected area.
   localparam int unsigned NW_FIT = (2 * NWORDS <= 32'(LMT_SIZE)) ? NWORDS : 32'(LMT_SIZE) / 2;
   localparam int unsigned NW_EFF = (NW_FIT < 1) ? 1 : ((NW_FIT > 4) ? 4 : NW_FIT);
   localparam logic [1:0]  IDX_LAST = 2'(NW_EFF - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [63:0] snap_q, snap_d;
   logic        pend_q, pend_d;
   logic [63:0] ts_q;
   logic        wen_q, wen_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] din_q, din_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Select 16-bit word i of the snapshot; word 0 is least significant.
   function automatic logic [15:0] word_sel(input logic [63:0] v, input logic [1:0] i);
      logic [15:0] w;
      case (i)
         2'd0:    w = v[15:0];
         2'd1:    w = v[31:16];
         2'd2:    w = v[47:32];
         2'd3:    w = v[63:48];
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

   // Next-state logic; outputs are derived from the next state so that
   // every port comes straight from a flop.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      snap_d  = snap_q;
      pend_d  = pend_q;
      case (state_q)
         S_IDLE: begin
            if (upLMT || pend_q) begin
               snap_d  = ts_q;
               idx_d   = 2'd0;
               pend_d  = 1'b0;
               state_d = S_WRITE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            if (upLMT) begin
               pend_d = 1'b1;
            end else begin
               pend_d = pend_q;
            end
            if (mem_ready) begin
               if (idx_q == IDX_LAST) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end else begin
               state_d = S_WRITE;
            end
         end
         S_DONE: begin
            if (upLMT) begin
               pend_d = 1'b1;
            end else begin
               pend_d = pend_q;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            pend_d  = 1'b0;
         end
      endcase

      wen_d  = (state_d == S_WRITE);
      busy_d = (state_d == S_WRITE);
      done_d = (state_d == S_DONE);
      if (wen_d) begin
         addr_d = LMT_BASE + {13'b0, idx_d, 1'b0};
         din_d  = word_sel(snap_d, idx_d);
      end else begin
         addr_d = 16'h0000;
         din_d  = 16'h0000;
      end
   end

   // State, counter and registered output flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         snap_q  <= 64'h0;
         pend_q  <= 1'b0;
         ts_q    <= TS_INIT;
         wen_q   <= 1'b0;
         addr_q  <= 16'h0000;
         din_q   <= 16'h0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         pend_q  <= pend_d;
         ts_q    <= ts_q + 64'd1;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign mem_wen   = wen_q;
   assign mem_addr  = addr_q;
   assign mem_din   = din_q;
   assign lmt_busy  = busy_q;
   assign lmt_done  = done_q;
   assign timestamp = ts_q;

endmodule
